// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the RV32I 5-stage pipeline: load-use bubbles, redirect flushes,
// data-memory wait freeze with timeout. Optional perf counters under `HAZARD_PERF_CNT_EN`.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } hz_state_t;

    localparam logic [15:0] TIMEOUT_MAX  = 16'(MEM_TIMEOUT);
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    hz_state_t   state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        load_use;
    logic        mem_busy;
    logic        redirect_flush;

    always_comb begin
        load_use = idex_memread && (idex_rd != 5'd0) &&
                   ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                    (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
        mem_busy = dmem_req && !dmem_ready;
    end

    // Memory wait freezes everything; EX stays held, so a pending redirect or
    // load-use is simply re-evaluated on the cycle the freeze releases.
    always_comb begin
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        pipe_freeze    = 1'b0;
        redirect_flush = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            redirect_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = 16'd0;
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q != TIMEOUT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
                if (!mem_busy) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
        if (mem_busy && (wait_cnt_q == TIMEOUT_LAST)) begin
            mem_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign hz_state    = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (redirect_flush && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    logic unused_perf;
    assign unused_perf  = redirect_flush;
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=8); perf expectations follow
// whether HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        ifid_use_rs1;
    logic        ifid_use_rs2;
    logic        ex_redirect;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pipe_freeze;
    logic        mem_timeout;
    logic [1:0]  hz_state;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    logic [4:0]  ctrl;
    int          totalChecks;
    int          badChecks;

    // ctrl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}
    localparam logic [4:0] C_RESET  = 5'b00110;
    localparam logic [4:0] C_IDLE   = 5'b11000;
    localparam logic [4:0] C_LU     = 5'b00010;
    localparam logic [4:0] C_REDIR  = 5'b11110;
    localparam logic [4:0] C_FREEZE = 5'b00001;

    hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout), .hz_state(hz_state),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctrl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r, input logic mr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic redir,
                                 input logic req, input logic rdy);
        @(negedge clk);
        rst          = r;
        idex_memread = mr;
        idex_rd      = rd;
        ifid_rs1     = rs1;
        ifid_rs2     = rs2;
        ifid_use_rs1 = u1;
        ifid_use_rs2 = u2;
        ex_redirect  = redir;
        dmem_req     = req;
        dmem_ready   = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        totalChecks  = 0;
        badChecks    = 0;
        rst          = 1'b1;
        idex_memread = 1'b0;
        idex_rd      = 5'd0;
        ifid_rs1     = 5'd0;
        ifid_rs2     = 5'd0;
        ifid_use_rs1 = 1'b0;
        ifid_use_rs2 = 1'b0;
        ex_redirect  = 1'b0;
        dmem_req     = 1'b0;
        dmem_ready   = 1'b0;

        // Reset held three cycles, with a busy/redirect pattern on the inputs in the last one
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_ctrl0", 32'(ctrl), 32'(C_RESET));
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_ctrl1", 32'(ctrl), 32'(C_RESET));
        checkOutput("rst_state", 32'(hz_state), 32'd0);
        applyStimulus(1, 1, 5, 0, 5, 0, 1, 1, 1, 0);
        checkOutput("rst_ctrl2", 32'(ctrl), 32'(C_RESET));
        checkOutput("rst_tmo", 32'(mem_timeout), 32'd0);
        checkOutput("rst_stall", stall_cycles, 32'd0);
        checkOutput("rst_flush", flush_count, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("release_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("release_state", 32'(hz_state), 32'd0);

        // Load-use detection
        applyStimulus(0, 1, 5, 0, 5, 0, 1, 0, 0, 0);
        checkOutput("lu_rs2", 32'(ctrl), 32'(C_LU));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lu_after", 32'(ctrl), 32'(C_IDLE));
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("lu_rd0", 32'(ctrl), 32'(C_IDLE));
        applyStimulus(0, 1, 5, 0, 5, 0, 0, 0, 0, 0);
        checkOutput("lu_nouse", 32'(ctrl), 32'(C_IDLE));
        applyStimulus(0, 1, 7, 7, 3, 1, 0, 0, 0, 0);
        checkOutput("lu_rs1", 32'(ctrl), 32'(C_LU));
        applyStimulus(0, 0, 7, 7, 3, 1, 0, 0, 0, 0);
        checkOutput("lu_noload", 32'(ctrl), 32'(C_IDLE));

        // Redirect beats load-use
        applyStimulus(0, 1, 5, 0, 5, 0, 1, 1, 0, 0);
        checkOutput("redir_lu", 32'(ctrl), 32'(C_REDIR));

        // Memory wait, four busy cycles with a redirect pending
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("mw_ctrl1", 32'(ctrl), 32'(C_FREEZE));
        checkOutput("mw_state1", 32'(hz_state), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            checkOutput("mw_ctrl", 32'(ctrl), 32'(C_FREEZE));
            checkOutput("mw_state", 32'(hz_state), 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkOutput("mw_ready_ctrl", 32'(ctrl), 32'(C_REDIR));
        checkOutput("mw_ready_state", 32'(hz_state), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mw_done_state", 32'(hz_state), 32'd0);
        checkOutput("mw_done_tmo", 32'(mem_timeout), 32'd0);

        // Request withdrawn while waiting
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("drop_wait_state", 32'(hz_state), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drop_ctrl", 32'(ctrl), 32'(C_IDLE));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("drop_state", 32'(hz_state), 32'd0);
        checkOutput("drop_tmo", 32'(mem_timeout), 32'd0);

        // Reset in the middle of a wait
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("mid_rst_ctrl", 32'(ctrl), 32'(C_RESET));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid_rst_state", 32'(hz_state), 32'd0);
        checkOutput("mid_rst_ctrl2", 32'(ctrl), 32'(C_IDLE));

        // Timeout: flag appears once eight wait-state cycles have elapsed
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("tmo_freeze", 32'(ctrl), 32'(C_FREEZE));
            checkOutput("tmo_flag", 32'(mem_timeout), (k == 10) ? 32'd1 : 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("tmo_ready_ctrl", 32'(ctrl), 32'(C_IDLE));
        checkOutput("tmo_ready_flag", 32'(mem_timeout), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("tmo_sticky", 32'(mem_timeout), 32'd1);
        checkOutput("tmo_state", 32'(hz_state), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("tmo_cleared", 32'(mem_timeout), 32'd0);

        // Perf scenario: 2 load-use, 1 redirect, 3-cycle memory wait
        applyStimulus(0, 1, 9, 9, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 4, 0, 4, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_stall", stall_cycles, 32'd5);
        checkOutput("perf_flush", flush_count, 32'd1);
`else
        checkOutput("perf_stall", stall_cycles, 32'd0);
        checkOutput("perf_flush", flush_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
